// File: rtl/game_timer_ctrl_if.sv
// Bundle between the game-level sequencer logic and game_timer_ctrl:
// game FSM pulses and timer readback in, phase/timer control and
// level-time results out. The master side drives the game pulses and
// timer values; the slave side is the controller.
interface game_timer_ctrl_if #(
  parameter int DIGIT_WIDTH = 6
);
  logic                   one_sec;
  logic                   start;
  logic                   pause_toggle;
  logic                   level_done;
  logic                   player_dead;
  logic [DIGIT_WIDTH-1:0] seconds;
  logic [DIGIT_WIDTH-1:0] minutes;

  logic                   timer_enable;
  logic                   timer_clear;
  logic [2:0]             state;
  logic [1:0]             countdown;
  logic [3:0]             level;
  logic                   time_up;
  logic [DIGIT_WIDTH-1:0] level_sec;
  logic [DIGIT_WIDTH-1:0] level_min;

  modport master (
    output one_sec, start, pause_toggle, level_done, player_dead, seconds, minutes,
    input  timer_enable, timer_clear, state, countdown, level, time_up, level_sec, level_min
  );

  modport slave (
    input  one_sec, start, pause_toggle, level_done, player_dead, seconds, minutes,
    output timer_enable, timer_clear, state, countdown, level, time_up, level_sec, level_min
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: phase sequencer for the in-game stopwatch.
// Tracks idle / countdown / running / paused / level-end / game-over,
// drives the timer enable and clear, counts levels and latches each
// level's completion time.
// Optional feature: define TIMER_CTRL_TIME_LIMIT_EN to build the
// per-level time-limit compare and the time_up pulse; otherwise time_up
// is tied low and LIMIT_MIN/LIMIT_SEC are unused.
module game_timer_ctrl #(
  parameter int DIGIT_WIDTH    = 6,
  parameter int COUNTDOWN_SECS = 3,
  parameter int LIMIT_MIN      = 2,
  parameter int LIMIT_SEC      = 0,
  parameter int MAX_LEVEL      = 15
) (
  input  logic              clk,
  input  logic              reset,
  game_timer_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUNNING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_LEVEL_END = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  localparam logic [1:0] CD_INIT   = 2'(COUNTDOWN_SECS);
  localparam logic [3:0] LEVEL_TOP = 4'(MAX_LEVEL);

  state_e                 state_q, state_d;
  logic [1:0]             countdown_q, countdown_d;
  logic [3:0]             level_q, level_d;
  logic                   timer_clear_q, timer_clear_d;
  logic [DIGIT_WIDTH-1:0] level_sec_q, level_sec_d;
  logic [DIGIT_WIDTH-1:0] level_min_q, level_min_d;
  logic                   limit_hit;

`ifdef TIMER_CTRL_TIME_LIMIT_EN
  logic time_up_q, time_up_d;

  // Exact compare against the configured limit, only while the clock runs.
  assign limit_hit = (state_q == S_RUNNING) &&
                     (bus.minutes == DIGIT_WIDTH'(LIMIT_MIN)) &&
                     (bus.seconds == DIGIT_WIDTH'(LIMIT_SEC));
  // time_up only flags a game over actually caused by the limit.
  assign time_up_d = limit_hit && !bus.player_dead;
`else
  assign limit_hit = 1'b0;
`endif

  // Next-state and next-output decode for every phase.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    countdown_d   = countdown_q;
    level_d       = level_q;
    timer_clear_d = 1'b0;
    level_sec_d   = level_sec_q;
    level_min_d   = level_min_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_COUNTDOWN;
          level_d       = 4'd1;
          countdown_d   = CD_INIT;
          timer_clear_d = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (bus.one_sec) begin
          if (countdown_q <= 2'd1) begin
            state_d     = S_RUNNING;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      S_RUNNING: begin
        if (bus.player_dead || limit_hit) begin
          state_d = S_GAME_OVER;
        end else if (bus.level_done) begin
          state_d     = S_LEVEL_END;
          level_sec_d = bus.seconds;
          level_min_d = bus.minutes;
        end else if (bus.pause_toggle) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (bus.player_dead) begin
          state_d = S_GAME_OVER;
        end else if (bus.pause_toggle) begin
          state_d = S_RUNNING;
        end
      end
      S_LEVEL_END: begin
        if (bus.start) begin
          state_d       = S_COUNTDOWN;
          level_d       = (level_q >= LEVEL_TOP) ? LEVEL_TOP : level_q + 4'd1;
          countdown_d   = CD_INIT;
          timer_clear_d = 1'b1;
        end
      end
      S_GAME_OVER: begin
        if (bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      countdown_q   <= 2'd0;
      level_q       <= 4'd0;
      timer_clear_q <= 1'b0;
      level_sec_q   <= '0;
      level_min_q   <= '0;
`ifdef TIMER_CTRL_TIME_LIMIT_EN
      time_up_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      countdown_q   <= countdown_d;
      level_q       <= level_d;
      timer_clear_q <= timer_clear_d;
      level_sec_q   <= level_sec_d;
      level_min_q   <= level_min_d;
`ifdef TIMER_CTRL_TIME_LIMIT_EN
      time_up_q     <= time_up_d;
`endif
    end
  end

  assign bus.state        = state_q;
  assign bus.countdown    = countdown_q;
  assign bus.level        = level_q;
  assign bus.timer_clear  = timer_clear_q;
  assign bus.level_sec    = level_sec_q;
  assign bus.level_min    = level_min_q;
  assign bus.timer_enable = (state_q == S_RUNNING);
`ifdef TIMER_CTRL_TIME_LIMIT_EN
  assign bus.time_up      = time_up_q;
`else
  assign bus.time_up      = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl. Each scenario task builds a
// plan of one-cycle stimulus steps; each step pushes its expected
// outputs to a scoreboard queue when driven, and the task pops and
// compares once the registered outputs have settled after the edge.
module tb_game_timer_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] cd;
    logic [3:0] lvl;
    logic       clr;
    logic       tu;
    logic       en;
    logic [5:0] lsec;
    logic [5:0] lmin;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       os;
    logic       st;
    logic       pt;
    logic       ld;
    logic       pd;
    logic [5:0] sec;
    logic [5:0] mn;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    out_t  e;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  step_t plan[$];
  out_t  exp_q[$];
  string name_q[$];

  game_timer_ctrl_if #(.DIGIT_WIDTH(6)) bus();

  game_timer_ctrl #(
    .DIGIT_WIDTH(6), .COUNTDOWN_SECS(3), .LIMIT_MIN(2), .LIMIT_SEC(0), .MAX_LEVEL(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(bit os = 0, bit start = 0, bit pt = 0, bit ld = 0,
                               bit pd = 0, int sec = 0, int mn = 0, bit rst = 0);
    stim_t s;
    s.rst = rst; s.os = os; s.st = start; s.pt = pt; s.ld = ld; s.pd = pd;
    s.sec = 6'(sec); s.mn = 6'(mn);
    return s;
  endfunction

  function automatic out_t ex(int state, int cd, int lvl, bit clr, bit tu, int lsec, int lmin);
    out_t o;
    o.state = 3'(state); o.cd = 2'(cd); o.lvl = 4'(lvl); o.clr = clr; o.tu = tu;
    o.en = (state == 2); o.lsec = 6'(lsec); o.lmin = 6'(lmin);
    return o;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.state = bus.state; o.cd = bus.countdown; o.lvl = bus.level; o.clr = bus.timer_clear;
    o.tu = bus.time_up; o.en = bus.timer_enable; o.lsec = bus.level_sec; o.lmin = bus.level_min;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("state=%0d cd=%0d lvl=%0d clr=%0b tu=%0b en=%0b lsec=%0d lmin=%0d",
                     o.state, o.cd, o.lvl, o.clr, o.tu, o.en, o.lsec, o.lmin);
  endfunction

  function automatic void add(string name, stim_t s, out_t e);
    step_t t;
    t.name = name; t.s = s; t.e = e;
    plan.push_back(t);
  endfunction

  // Drive one step's inputs, record its expectation, let one edge pass.
  task automatic send(step_t t);
    reset            = t.s.rst;
    bus.one_sec      = t.s.os;
    bus.start        = t.s.st;
    bus.pause_toggle = t.s.pt;
    bus.level_done   = t.s.ld;
    bus.player_dead  = t.s.pd;
    bus.seconds      = t.s.sec;
    bus.minutes      = t.s.mn;
    exp_q.push_back(t.e);
    name_q.push_back(t.name);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e; string n;
    add("reset_0", st(0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    add("reset_1", st(0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    add("idle_hold", st(), ex(0, 0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_start_countdown();
    out_t e; string n;
    add("start", st(0, 1), ex(1, 3, 1, 1, 0, 0, 0));
    add("clear_one_cycle", st(), ex(1, 3, 1, 0, 0, 0, 0));
    add("cd_3to2", st(1), ex(1, 2, 1, 0, 0, 0, 0));
    add("cd_ignores_others", st(1, 1, 1, 1, 1), ex(1, 1, 1, 0, 0, 0, 0));
    add("cd_hold", st(), ex(1, 1, 1, 0, 0, 0, 0));
    add("cd_to_running", st(1), ex(2, 0, 1, 0, 0, 0, 0));
    add("running_hold", st(), ex(2, 0, 1, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_pause();
    out_t e; string n;
    add("pause", st(0, 0, 1), ex(3, 0, 1, 0, 0, 0, 0));
    add("paused_ignores_done", st(0, 0, 0, 1), ex(3, 0, 1, 0, 0, 0, 0));
    add("paused_ignores_start", st(0, 1), ex(3, 0, 1, 0, 0, 0, 0));
    add("resume", st(0, 0, 1), ex(2, 0, 1, 0, 0, 0, 0));
    add("tick_and_pause", st(1, 0, 1), ex(3, 0, 1, 0, 0, 0, 0));
    add("resume_again", st(0, 0, 1), ex(2, 0, 1, 0, 0, 0, 0));
    add("running_ignores_start", st(0, 1), ex(2, 0, 1, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_level_end();
    out_t e; string n;
    add("level_done_latch", st(0, 0, 0, 1, 0, 27, 1), ex(4, 0, 1, 0, 0, 27, 1));
    add("latch_holds", st(0, 0, 0, 0, 0, 5, 5), ex(4, 0, 1, 0, 0, 27, 1));
    add("level_end_ignores_pause", st(0, 0, 1), ex(4, 0, 1, 0, 0, 27, 1));
    add("next_level_start", st(0, 1), ex(1, 3, 2, 1, 0, 27, 1));
    add("lvl2_cd2", st(1), ex(1, 2, 2, 0, 0, 27, 1));
    add("lvl2_cd1", st(1), ex(1, 1, 2, 0, 0, 27, 1));
    add("lvl2_running", st(1), ex(2, 0, 2, 0, 0, 27, 1));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_priority();
    out_t e; string n;
    add("dead_beats_done_pause", st(0, 0, 1, 1, 1, 3, 3), ex(5, 0, 2, 0, 0, 27, 1));
    add("game_over_hold", st(), ex(5, 0, 2, 0, 0, 27, 1));
    add("game_over_to_idle", st(0, 1), ex(0, 0, 2, 0, 0, 27, 1));
    add("new_game", st(0, 1), ex(1, 3, 1, 1, 0, 27, 1));
    add("ng_cd2", st(1), ex(1, 2, 1, 0, 0, 27, 1));
    add("ng_cd1", st(1), ex(1, 1, 1, 0, 0, 27, 1));
    add("ng_running", st(1), ex(2, 0, 1, 0, 0, 27, 1));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_time_limit();
    out_t e; string n;
    add("below_limit", st(0, 0, 0, 0, 0, 59, 1), ex(2, 0, 1, 0, 0, 27, 1));
    add("past_limit_inexact", st(0, 0, 0, 0, 0, 1, 2), ex(2, 0, 1, 0, 0, 27, 1));
`ifdef TIMER_CTRL_TIME_LIMIT_EN
    add("limit_hit", st(0, 0, 0, 0, 0, 0, 2), ex(5, 0, 1, 0, 1, 27, 1));
    add("time_up_one_cycle", st(0, 0, 0, 0, 0, 0, 2), ex(5, 0, 1, 0, 0, 27, 1));
`else
    add("no_limit_logic", st(0, 0, 0, 0, 0, 0, 2), ex(2, 0, 1, 0, 0, 27, 1));
    add("no_limit_hold", st(0, 0, 0, 0, 0, 0, 2), ex(2, 0, 1, 0, 0, 27, 1));
    add("dead_ends_game", st(0, 0, 0, 0, 1), ex(5, 0, 1, 0, 0, 27, 1));
`endif
    add("back_to_idle", st(0, 1), ex(0, 0, 1, 0, 0, 27, 1));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t e; string n;
    add("rm_start", st(0, 1), ex(1, 3, 1, 1, 0, 27, 1));
    add("rm_cd2", st(1), ex(1, 2, 1, 0, 0, 27, 1));
    add("rm_cd1", st(1), ex(1, 1, 1, 0, 0, 27, 1));
    add("rm_running", st(1), ex(2, 0, 1, 0, 0, 27, 1));
    add("rm_paused", st(0, 0, 1), ex(3, 0, 1, 0, 0, 27, 1));
    add("rm_reset", st(0, 1, 1, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    add("rm_no_clear", st(), ex(0, 0, 0, 0, 0, 0, 0));
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  task automatic test_saturation();
    out_t e; string n;
    int lvl = 1;
    int lsec = 0;
    add("sat_start", st(0, 1), ex(1, 3, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 16; i++) begin
      add($sformatf("sat%0d_cd2", i), st(1), ex(1, 2, lvl, 0, 0, lsec, 0));
      add($sformatf("sat%0d_cd1", i), st(1), ex(1, 1, lvl, 0, 0, lsec, 0));
      add($sformatf("sat%0d_run", i), st(1), ex(2, 0, lvl, 0, 0, lsec, 0));
      lsec = i;
      add($sformatf("sat%0d_done", i), st(0, 0, 0, 1, 0, i, 0), ex(4, 0, lvl, 0, 0, lsec, 0));
      lvl = (lvl < 15) ? lvl + 1 : 15;
      add($sformatf("sat%0d_next", i), st(0, 1), ex(1, 3, lvl, 1, 0, lsec, 0));
    end
    while (plan.size() > 0) begin
      send(plan.pop_front());
      e = exp_q.pop_front(); n = name_q.pop_front(); total++;
      if (observe() !== e) begin
        bad++; $display("FAIL %s: got %s expected %s", n, fmt(observe()), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_countdown();
    test_pause();
    test_level_end();
    test_priority();
    test_time_limit();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Sequencer for the in-game stopwatch. It owns the game phase (idle, pre-level countdown, running, paused, level end, game over) and drives the timer's enable and clear. It enforces an optional per-level time limit and latches each level's completion time for the score/bonus logic. It sits between the top-level game FSM inputs (start, pause, level done, player death), the shared one-second pulse and the `game_timer` instance.

## Interface
Parameters:
- `DIGIT_WIDTH`, 6: width of the seconds/minutes buses; matches the timer.
- `COUNTDOWN_SECS`, 3: pre-level countdown length in seconds; legal range 1..3.
- `LIMIT_MIN`, 2: time-limit minutes value.
- `LIMIT_SEC`, 0: time-limit seconds value, < 60.
- `MAX_LEVEL`, 15: highest level number; the level counter saturates here.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `one_sec` in 1: single-cycle pulse once per second, from the shared one-second counter.
- `start` in 1: start pulse for a new game or next level.
- `pause_toggle` in 1: pulse that toggles between pause and run.
- `level_done` in 1: pulse when all invaders are cleared.
- `player_dead` in 1: pulse when the last life is lost.
- `seconds` in DIGIT_WIDTH: current timer seconds.
- `minutes` in DIGIT_WIDTH: current timer minutes.
- `timer_enable` out 1: connects to the timer `enable`.
- `timer_clear` out 1: one-cycle clear request to the timer reset logic.
- `state` out 3: current phase encoding.
- `countdown` out 2: remaining countdown seconds, for display.
- `level` out 4: current level number.
- `time_up` out 1: one-cycle pulse when the time limit is hit.
- `level_sec` out DIGIT_WIDTH: completion time of the last level, seconds.
- `level_min` out DIGIT_WIDTH: completion time of the last level, minutes.

## Operation
States and encodings: IDLE=0, COUNTDOWN=1, RUNNING=2, PAUSED=3, LEVEL_END=4, GAME_OVER=5. Encodings 6 and 7 return to IDLE on the next cycle.

Transitions:
- **IDLE, `start`:** go to COUNTDOWN. Set `level`<=1, `countdown`<=COUNTDOWN_SECS, pulse `timer_clear`.
- **COUNTDOWN, `one_sec`:** decrement `countdown`. When `countdown`==1 and `one_sec` arrives, go to RUNNING with `countdown`<=0. All other inputs are ignored.
- **RUNNING:** inputs are evaluated in priority order `player_dead` > time-limit hit > `level_done` > `pause_toggle`.
  - `player_dead` → GAME_OVER.
  - Time-limit hit → GAME_OVER.
  - `level_done` → LEVEL_END. Latch `level_sec`/`level_min` from `seconds`/`minutes` on that cycle.
  - `pause_toggle` → PAUSED.
- **PAUSED:**
  - `pause_toggle` → RUNNING.
  - `player_dead` → GAME_OVER; this takes priority over `pause_toggle`.
  - `level_done` is ignored.
- **LEVEL_END, `start`:** go to COUNTDOWN. Increment `level`, saturating at MAX_LEVEL. Reload `countdown` and pulse `timer_clear`.
- **GAME_OVER, `start`:** go to IDLE. `level`, `level_sec` and `level_min` hold until the next game starts.

Output rules:
- `timer_enable` = (`state`==RUNNING), decoded from the registered state.
- `timer_clear` is registered. It is high for exactly the cycle after the transition into COUNTDOWN.
- Time-limit hit = RUNNING && {`minutes`,`seconds`} == {LIMIT_MIN, LIMIT_SEC}, as an exact compare. `time_up` is high for one cycle, the cycle after the hit, concurrently with `state` showing GAME_OVER.
- `start` is ignored in COUNTDOWN, RUNNING and PAUSED.

## Timing
- All outputs are registered except `timer_enable`, which is decoded from the registered state.
- State change takes effect 1 cycle after the qualifying input pulse.
- Reset values: `state`=IDLE, `countdown`=0, `level`=0, `timer_clear`=0, `time_up`=0, `level_sec`=0, `level_min`=0, `timer_enable`=0.
- Reset mid-operation returns to IDLE within 1 cycle. No `timer_clear` is issued, because the timer is reset by its own reset.
- Simultaneous `one_sec` and `pause_toggle` in RUNNING: go to PAUSED. The timer still counts that tick, because `timer_enable` was high that cycle.
- Simultaneous `level_done` and a time-limit hit: GAME_OVER wins.
- `level` increment at MAX_LEVEL holds at MAX_LEVEL.

## Configuration
- **Macro `TIMER_CTRL_TIME_LIMIT_EN`.**
- **When defined:** the time-limit compare and the `time_up` pulse are built as described above.
- **When undefined:** no compare logic is built, `time_up` is tied to 0, and RUNNING exits only via `player_dead`, `level_done` or `pause_toggle`. LIMIT_MIN and LIMIT_SEC are unused.

## Test plan
- **Start and countdown:** reset, then `start`. Required: `timer_clear` high for 1 cycle; `countdown` 3→2→1 on successive `one_sec` pulses; the third pulse gives RUNNING with `countdown`=0 and `timer_enable`=1.
- **Pause:** in RUNNING, pulse `pause_toggle`. Required: `state`=3 and `timer_enable`=0 next cycle. Pulse `pause_toggle` again → RUNNING. `level_done` while paused → no state change.
- **Level end:**
  - Drive `minutes`=1, `seconds`=27 and pulse `level_done`. Required: LEVEL_END, `level_sec`=27, `level_min`=1.
  - Then `start`. Required: `level`=2, COUNTDOWN, `timer_clear` pulse.
- **Time limit (macro defined):** drive `minutes`=2, `seconds`=0 in RUNNING. Required: GAME_OVER and a 1-cycle `time_up`. The same stimulus with the macro undefined → stays RUNNING, `time_up`=0.
- **Priority:** `player_dead`, `level_done` and `pause_toggle` pulsed in the same cycle in RUNNING. Required: GAME_OVER, `level_sec`/`level_min` unchanged.
- **Reset and saturation:**
  - `reset` asserted in PAUSED. Required: all outputs at reset values next cycle.
  - Advance through 16 levels. Required: `level` holds at 15.
